// File: rtl/sort_feeder_if.sv
// Handshake and window bus between the pixel source, the feeder and the
// compare chain of the 7-input transposition sorter.
interface sort_feeder_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  flush;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out0;
    logic [DATA_WIDTH-1:0] out1;
    logic [DATA_WIDTH-1:0] out2;
    logic [DATA_WIDTH-1:0] out3;
    logic [DATA_WIDTH-1:0] out4;
    logic [DATA_WIDTH-1:0] out5;
    logic [DATA_WIDTH-1:0] out6;
    logic                  refresh;
    logic                  busy;
    logic                  result_valid;

    modport master (
        output flush, in_valid, in_data,
        input  in_ready, out0, out1, out2, out3, out4, out5, out6,
        input  refresh, busy, result_valid
    );

    modport slave (
        input  flush, in_valid, in_data,
        output in_ready, out0, out1, out2, out3, out4, out5, out6,
        output refresh, busy, result_valid
    );
endinterface

// File: rtl/sort_feeder.sv
// Gathers 7 serial samples into a window, holds it for the sorter settle time,
// then pulses result_valid/refresh and reopens for the next batch.
module sort_feeder #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned SORT_LATENCY = 14
) (
    input  logic         clk,
    input  logic         rst,
    sort_feeder_if.slave bus
);
    localparam int unsigned N_TAPS = 7;
    localparam int unsigned FILL_W = 3;
    localparam int unsigned WAIT_W = 8;
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(N_TAPS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SORT_LATENCY - 1);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [FILL_W-1:0]     fill_cnt_q, fill_cnt_d;
    logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic [DATA_WIDTH-1:0] smp_q [N_TAPS];
    logic [DATA_WIDTH-1:0] smp_d [N_TAPS];
    logic [DATA_WIDTH-1:0] out_q [N_TAPS];
    logic [DATA_WIDTH-1:0] out_d [N_TAPS];
    logic                  refresh_q, refresh_d;
    logic                  result_valid_q, result_valid_d;
    logic                  in_ready;
    logic                  busy;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_FILL;
            fill_cnt_q     <= '0;
            wait_cnt_q     <= '0;
            refresh_q      <= 1'b0;
            result_valid_q <= 1'b0;
            for (int unsigned k = 0; k < N_TAPS; k++) begin
                smp_q[k] <= '0;
                out_q[k] <= '0;
            end
        end else begin
            state_q        <= state_d;
            fill_cnt_q     <= fill_cnt_d;
            wait_cnt_q     <= wait_cnt_d;
            refresh_q      <= refresh_d;
            result_valid_q <= result_valid_d;
            for (int unsigned k = 0; k < N_TAPS; k++) begin
                smp_q[k] <= smp_d[k];
                out_q[k] <= out_d[k];
            end
        end
    end

    // Next state, sample capture and counters; flush overrides everything
    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        wait_cnt_d = wait_cnt_q;
        smp_d      = smp_q;
        case (state_q)
            S_FILL: begin
                if (bus.in_valid) begin
                    for (int unsigned k = 0; k < N_TAPS; k++) begin
                        if (fill_cnt_q == FILL_W'(k)) smp_d[k] = bus.in_data;
                    end
                    if (fill_cnt_q == FILL_LAST) begin
                        fill_cnt_d = '0;
                        state_d    = S_ISSUE;
                    end else begin
                        fill_cnt_d = fill_cnt_q + FILL_W'(1);
                    end
                end
            end
            S_ISSUE: begin
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                if (wait_cnt_q == WAIT_LAST) state_d = S_DONE;
            end
            S_DONE:  state_d = S_FILL;
            default: state_d = S_FILL;
        endcase
        if (bus.flush) begin
            state_d    = S_FILL;
            fill_cnt_d = '0;
            wait_cnt_d = '0;
            smp_d      = smp_q;
        end
    end

    // Output decode: window load/clear and the registered pulses
    always_comb begin
        out_d          = out_q;
        refresh_d      = 1'b0;
        result_valid_d = 1'b0;
        in_ready       = (state_q == S_FILL);
        busy           = (state_q != S_FILL);
        if (state_q == S_ISSUE) out_d = smp_q;
        if (state_q == S_DONE) begin
            for (int unsigned k = 0; k < N_TAPS; k++) out_d[k] = '0;
        end
        if (state_d == S_DONE) begin
            refresh_d      = 1'b1;
            result_valid_d = 1'b1;
        end
        if (bus.flush) begin
            for (int unsigned k = 0; k < N_TAPS; k++) out_d[k] = '0;
            refresh_d      = 1'b1;
            result_valid_d = 1'b0;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.busy         = busy;
    assign bus.refresh      = refresh_q;
    assign bus.result_valid = result_valid_q;
    assign bus.out0         = out_q[0];
    assign bus.out1         = out_q[1];
    assign bus.out2         = out_q[2];
    assign bus.out3         = out_q[3];
    assign bus.out4         = out_q[4];
    assign bus.out5         = out_q[5];
    assign bus.out6         = out_q[6];
endmodule

// File: doc/sort_feeder.md
Name: sort_feeder

Overview:
- Upstream stage of the 7-input odd-even transposition sorter (the chain of compare stages).
- Accepts a serial pixel stream with a valid/ready handshake and gathers 7 samples into a window.
- Presents the window in parallel on out0..out6 and holds it stable while the compare chain settles.
- Then pulses result_valid and refresh (refresh clears the compare stages) and reopens for the next batch.

Parameters:
- DATA_WIDTH, 8: bits per sample; matches the compare stages.
- SORT_LATENCY, 14: hold cycles for the sorter chain (7 stages x 2 registered cycles). Legal range 1..255.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  synchronous abort of the current batch.
- in_valid  in  1  in_data carries a sample.
- in_data  in  DATA_WIDTH  sample value.
- in_ready  out  1  feeder accepts a sample this cycle.
- out0..out6  out  DATA_WIDTH each  parallel window to the first compare stage; out0 = first sample accepted.
- refresh  out  1  one-cycle clear pulse to every compare stage.
- busy  out  1  high in ISSUE, WAIT and DONE.
- result_valid  out  1  one-cycle pulse; sorter outputs are final this cycle.

Behaviour:
- Reset (rst=1 at an edge):
  - state FILL, fill count 0, wait count 0, buffer cleared to 0.
  - out0..out6 = 0, refresh = 0, result_valid = 0, busy = 0.
  - in_ready = 1 from the first cycle after reset.
- Priority: rst > flush > normal operation.
- Handshake:
  - in_ready = (state == FILL); it is combinational from state only.
  - A sample is accepted when in_valid && in_ready at a rising edge.
  - The k-th accepted sample (k = 0..6) is written to buf[k].
  - in_valid while in_ready = 0 is ignored; nothing is queued. The upstream source must hold its data.
- States:
  - FILL: accept samples; the fill count increments per acceptance. Accepting the 7th sample (count 6) moves to ISSUE and resets the count to 0.
  - ISSUE: lasts one cycle. out_k <= buf[k] for all k. Wait count <= 0. Next state WAIT.
  - WAIT: wait count increments each cycle. When it reaches SORT_LATENCY-1, the next state is DONE. WAIT therefore lasts exactly SORT_LATENCY cycles.
  - DONE: lasts one cycle. result_valid = 1 and refresh = 1. out0..out6 still hold the window. Next state FILL, and out0..out6 are cleared to 0 at that edge.
- Timing: if the 7 samples are accepted at consecutive edges t0..t6:
  - ISSUE occupies the cycle after t6.
  - The outputs are visible for SORT_LATENCY+1 cycles (WAIT plus DONE).
  - in_ready returns 1 in the cycle after DONE.
- Output stability: out0..out6 change only on the ISSUE->WAIT edge, the DONE->FILL edge, on flush, or on reset. They never change during WAIT.
- Flush (any state): at the next edge:
  - state FILL, fill count 0, wait count 0, out0..out6 = 0.
  - refresh = 1 for exactly the following cycle; result_valid = 0.
  - A sample offered in the same cycle as flush is dropped.
  - Flush during DONE suppresses nothing already visible; the DONE-cycle pulses have occurred.
- Outputs are registered: refresh and result_valid are registered outputs; busy is decoded from state.
- Partial batch: there is no timeout; a partial fill waits indefinitely for the remaining samples.
- Counter widths: the fill count is 3 bits. The wait count is 8 bits; there is no wrap, since it is reset in ISSUE.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid = 1 -> all outputs 0, in_ready = 1 after release, no sample captured.
- Basic batch (SORT_LATENCY = 14): feed 30,10,70,50,20,60,40 on 7 consecutive cycles ->
  - in_ready drops.
  - out0..out6 = 30,10,70,50,20,60,40 from 2 cycles after the last accept, held 15 cycles.
  - result_valid and refresh both high on the 15th of those cycles.
  - out = 0 and in_ready = 1 the next cycle.
- Gapped input: 7 samples with random in_valid gaps (values 1..7) -> same window order 1..7; offers during ISSUE/WAIT are not accepted and in_ready = 0 throughout.
- Flush mid-fill: accept 4 samples, then flush with in_valid = 1 -> refresh = 1 for one cycle, count restarts; the next 7 samples 9..15 appear as out0..out6 = 9..15.
- Flush in WAIT: flush on the 5th WAIT cycle -> outputs 0 next cycle, no result_valid pulse, refresh pulse once, in_ready = 1.
- Back-to-back batches with SORT_LATENCY = 1: two batches fed with in_valid held high -> WAIT lasts 1 cycle, result_valid once per batch, and the second window equals the second batch exactly.
